// File: rtl/pe_out_collector.sv
// pe_out_collector: requantises finished PE results and buffers them in a show-ahead FIFO
module pe_out_collector #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    finish_i,
    input  logic [IN_W-1:0]         pe_out_i,
    input  logic [$clog2(IN_W)-1:0] shift_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [OUT_W-1:0]        m_data_o,
    output logic                    m_sat_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic [7:0]              drop_cnt_o,
    input  logic                    clear_ovf_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic             fin_q;
    logic [OUT_W:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic [IN_W-1:0]  r;
    logic [OUT_W-1:0] qdata;
    logic             sat, push, pop, full, drop, wr;
    // Requantise the bus value and decide push/pop/drop for this edge
    always_comb begin
        r      = pe_out_i >> shift_i;
        sat    = |(r >> OUT_W);
        qdata  = sat ? '1 : r[OUT_W-1:0];
        push   = fin_q;
        pop    = m_valid_o && m_ready_i;
        full   = cnt_q == FULL_CNT;
        drop   = push && full && !pop;
        wr     = push && !drop;
        cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
        ovf_d  = drop ? 1'b1 : (clear_ovf_i ? 1'b0 : ovf_q);
        drop_d = drop ? (clear_ovf_i ? 8'd1 : (&drop_q ? drop_q : drop_q + 8'd1))
                      : (clear_ovf_i ? 8'd0 : drop_q);
    end
    // Control state: finish delay, pointers, occupancy and drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            fin_q  <= finish_i;
            wr_q   <= wr ? wr_q + 1'b1 : wr_q;
            rd_q   <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end
    // Entry storage; stale contents are unreachable once pointers are reset
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= {sat, qdata};
    end
    assign m_valid_o  = cnt_q != '0;
    assign m_data_o   = m_valid_o ? mem_q[rd_q][OUT_W-1:0] : '0;
    assign m_sat_o    = m_valid_o && mem_q[rd_q][OUT_W];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_pe_out_collector.sv
// tb_pe_out_collector: directed stimulus checked against a queue-based model and literals
module tb_pe_out_collector;
    localparam int DEPTH = 4;
    logic        clk = 0, rst = 1, finish = 0, m_ready = 0, clear_ovf = 0;
    logic [31:0] pe_out = 0;
    logic [4:0]  shift = 0;
    logic        m_valid, m_sat, overflow;
    logic [15:0] m_data;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;
    int          checks = 0, errors = 0;
    bit          go = 0;
    logic [16:0] mq[$];
    bit          m_fin = 0, m_ovf = 0;
    int          m_drop = 0;

    always #5 clk = ~clk;

    pe_out_collector #(.IN_W(32), .OUT_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .finish_i(finish), .pe_out_i(pe_out), .shift_i(shift),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_sat_o(m_sat),
        .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt), .clear_ovf_i(clear_ovf)
    );

    function automatic logic [16:0] requant(input logic [31:0] v, input logic [4:0] s);
        logic [31:0] r;
        r = v >> s;
        return (r > 32'd65535) ? {1'b1, 16'hFFFF} : {1'b0, r[15:0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Model: a result arriving one edge after finish joins the queue unless the queue is
    // full after this edge's pop; the head leaves when shown and accepted.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_fin = 0; m_ovf = 0; m_drop = 0;
        end else begin
            if (mq.size() != 0 && m_ready) void'(mq.pop_front());
            if (m_fin && mq.size() == DEPTH) begin
                m_ovf  = 1;
                m_drop = clear_ovf ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else begin
                if (m_fin) mq.push_back(requant(pe_out, shift));
                if (clear_ovf) begin m_ovf = 0; m_drop = 0; end
            end
            m_fin = finish;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            chk("count", 32'(count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (mq.size() != 0) chk("head", {15'd0, m_sat, m_data}, 32'(mq[0]));
        end
    end

    task automatic cyc(input logic f, input logic [31:0] v, input logic [4:0] s, input logic rdy);
        finish = f; pe_out = v; shift = s; m_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        finish = 1;
        repeat (3) @(negedge clk);
        finish = 0; rst = 0; go = 1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_sat", 32'(m_sat), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("lat_not_yet", 32'(m_valid), 0);
        cyc(0, 32'h0000_1234, 0, 0);
        chk("lat_valid", 32'(m_valid), 1);
        chk("t1_data", 32'(m_data), 32'h1234);
        chk("t1_sat", 32'(m_sat), 0);
        cyc(0, 0, 0, 0);
        chk("t1_hold", 32'(m_data), 32'h1234);
        cyc(0, 0, 0, 1);
        chk("t1_popped", 32'(count), 0);
        cyc(0, 0, 0, 1);
        chk("empty_ready", 32'(count), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 32'h0012_3400, 8, 0);
        cyc(0, 32'h0100_0000, 4, 0);
        chk("t2_count", 32'(count), 2);
        chk("t2_data", 32'(m_data), 32'h1234);
        chk("t2_sat", 32'(m_sat), 0);
        cyc(0, 0, 0, 1);
        chk("t2_sdata", 32'(m_data), 32'hFFFF);
        chk("t2_ssat", 32'(m_sat), 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 32'h0000_FFFF, 0, 0);
        cyc(0, 32'h0001_0000, 0, 0);
        chk("edge_nosat", {15'd0, m_sat, m_data}, 32'h0FFFF);
        cyc(0, 0, 0, 1);
        chk("edge_sat", {15'd0, m_sat, m_data}, 32'h1FFFF);
        cyc(0, 0, 0, 1);
        for (int i = 0; i <= 6; i++) cyc(i < 6, 32'(i), 0, 0);
        chk("t3_count", 32'(count), 4);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_drop", 32'(drop_cnt), 2);
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", 32'(m_data), 32'(k + 1));
            cyc(0, 0, 0, 1);
        end
        chk("t3_empty", 32'(count), 0);
        clear_ovf = 1;
        cyc(0, 0, 0, 0);
        clear_ovf = 0;
        chk("t3_clr_ovf", 32'(overflow), 0);
        chk("t3_clr_drop", 32'(drop_cnt), 0);
        for (int i = 0; i <= 4; i++) cyc(i < 4, 32'(9 + i), 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 32'd14, 0, 1);
        chk("t4_count", 32'(count), 4);
        chk("t4_drop", 32'(drop_cnt), 0);
        chk("t4_ovf", 32'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", 32'(m_data), 32'(11 + k));
            cyc(0, 0, 0, 1);
        end
        for (int i = 0; i <= 4; i++) cyc(i < 4, 32'(29 + i), 0, 0);
        cyc(1, 0, 0, 0);
        clear_ovf = 1;
        cyc(0, 32'd34, 0, 0);
        clear_ovf = 0;
        chk("clr_vs_drop_ovf", 32'(overflow), 1);
        chk("clr_vs_drop_cnt", 32'(drop_cnt), 1);
        chk("clr_vs_drop_head", 32'(m_data), 30);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 32'd21, 0, 1);
        chk("t5_beat1", 32'(m_data), 21);
        cyc(1, 32'd22, 0, 1);
        chk("t5_beat2", 32'(m_data), 22);
        cyc(0, 32'd23, 0, 1);
        chk("t5_beat3", 32'(m_data), 23);
        chk("t5_valid3", 32'(m_valid), 1);
        cyc(0, 0, 0, 1);
        chk("t5_drained", 32'(m_valid), 0);
        for (int i = 0; i < 270; i++) cyc(1, 32'(100 + i), 0, 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        rst = 1;
        cyc(0, 32'd55, 0, 0);
        rst = 0;
        chk("t6_valid", 32'(m_valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_drop", 32'(drop_cnt), 0);
        repeat (4) cyc(0, 0, 0, 0);
        chk("t6_no_stale", 32'(m_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
